// File: rtl/mc_cfg_pkg.sv
// rtl/mc_cfg_pkg.sv - shared types and field layout for the macrocell config loader
//
// Purpose: loader FSM state encoding, per-macrocell stream length and the
//          position of each field within a macrocell's 4-bit record.
// Ports:   none (package).
package mc_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    ERROR  = 2'd3
  } state_e;

  localparam int BITS_PER_MC = 4;

  // Field order within one macrocell record, first bit on the wire = 0.
  localparam int XINV = 0;
  localparam int OMUX = 1;
  localparam int DMUX = 2;
  localparam int PAR  = 3;

endpackage

// File: rtl/mc_cfg_slot.sv
// rtl/mc_cfg_slot.sv - one macrocell's shadow/active select registers
//
// Purpose: holds the three select bits being loaded (shadow) and the three
//          bits currently driving the macrocell (active).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   wr_en_i    per-field shadow write enable (XINV/OMUX/DMUX)
//   wr_bit_i   value written into every enabled shadow field
//   commit_i   copy shadow into active on this edge
//   active_o   active selects, indexed by XINV/OMUX/DMUX
//   par_o      XOR of the shadow fields, for the loader's parity check
module mc_cfg_slot
  import mc_cfg_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [PAR-1:0] wr_en_i,
  input  logic           wr_bit_i,
  input  logic           commit_i,
  output logic [PAR-1:0] active_o,
  output logic           par_o
);

  logic [PAR-1:0] shadow_q, shadow_d;
  logic [PAR-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    for (int b = 0; b < PAR; b++) begin
      if (wr_en_i[b]) shadow_d[b] = wr_bit_i;
    end
    active_d = commit_i ? shadow_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;
  // Every shadow field is rewritten before this macrocell's parity bit
  // arrives, so this is exactly b0^b1^b2 of the current load.
  assign par_o    = ^shadow_q;

endmodule

// File: rtl/mc_cfg_loader.sv
// rtl/mc_cfg_loader.sv - serial, parity-checked, atomically committed macrocell config loader
//
// Purpose: accepts 4*NUM_MC config bits (macrocell 0 first; xor_inv, o_mux,
//          d_mux, odd parity), stages them, and switches every macrocell to
//          the new selects on one edge once the whole stream checked good.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a load (honoured in IDLE/ERROR)
//   abort                    cancel; wins over every other event
//   cfg_bit/cfg_valid        serial stream input
//   cfg_ready                high while loading (registered)
//   xor_inv_mux/o_mux/d_mux  active per-macrocell selects
//   busy                     high in LOAD and COMMIT
//   done                     one-cycle pulse with the new selects
//   err/err_mc               sticky parity error and failing macrocell
module mc_cfg_loader
  import mc_cfg_pkg::*;
#(
  parameter int NUM_MC = 16,
  parameter int MCW    = (NUM_MC > 1) ? $clog2(NUM_MC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_bit,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [NUM_MC-1:0] xor_inv_mux,
  output logic [NUM_MC-1:0] o_mux,
  output logic [NUM_MC-1:0] d_mux,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [MCW-1:0]    err_mc
);

  localparam int BIW = $clog2(BITS_PER_MC);

  state_e           state_q, state_d;
  logic [BIW-1:0]   bit_idx_q, bit_idx_d;
  logic [MCW-1:0]   mc_idx_q, mc_idx_d;
  logic             err_q, err_d;
  logic [MCW-1:0]   err_mc_q, err_mc_d;
  logic             cfg_ready_q, busy_q, done_q;

  logic             accept, commit, par_ok, last_mc;
  logic [PAR-1:0]   bit_dec;
  logic [NUM_MC-1:0] par_vec;
  logic [PAR-1:0]   slot_we  [NUM_MC];
  logic [PAR-1:0]   slot_act [NUM_MC];

  assign accept  = cfg_valid && cfg_ready_q;
  assign par_ok  = par_vec[mc_idx_q] ^ cfg_bit;
  assign last_mc = (mc_idx_q == MCW'(NUM_MC - 1));

  always_comb begin
    bit_dec = '0;
    for (int b = 0; b < PAR; b++) begin
      bit_dec[b] = (bit_idx_q == BIW'(b));
    end
  end

  for (genvar i = 0; i < NUM_MC; i++) begin : g_slot
    assign slot_we[i] = (accept && (mc_idx_q == MCW'(i))) ? bit_dec : '0;

    mc_cfg_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (slot_we[i]),
      .wr_bit_i (cfg_bit),
      .commit_i (commit),
      .active_o (slot_act[i]),
      .par_o    (par_vec[i])
    );

    assign xor_inv_mux[i] = slot_act[i][XINV];
    assign o_mux[i]       = slot_act[i][OMUX];
    assign d_mux[i]       = slot_act[i][DMUX];
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    mc_idx_d  = mc_idx_q;
    err_d     = err_q;
    err_mc_d  = err_mc_q;
    commit    = 1'b0;
    unique case (state_q)
      IDLE, ERROR: begin
        // Any new load clears the previous error so done and err never overlap.
        if (start && !abort) begin
          state_d   = LOAD;
          bit_idx_d = '0;
          mc_idx_d  = '0;
          err_d     = 1'b0;
          err_mc_d  = '0;
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (bit_idx_q == BIW'(PAR)) begin
            bit_idx_d = '0;
            mc_idx_d  = mc_idx_q + MCW'(1);
            if (!par_ok) begin
              state_d  = ERROR;
              err_d    = 1'b1;
              err_mc_d = mc_idx_q;
            end else if (last_mc) begin
              state_d = COMMIT;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIW'(1);
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      mc_idx_q    <= '0;
      err_q       <= 1'b0;
      err_mc_q    <= '0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      mc_idx_q    <= mc_idx_d;
      err_q       <= err_d;
      err_mc_q    <= err_mc_d;
      cfg_ready_q <= (state_d == LOAD);
      busy_q      <= (state_d == LOAD) || (state_d == COMMIT);
      done_q      <= commit;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mc    = err_mc_q;

endmodule

// File: tb/tb_mc_cfg_loader.sv
// tb/tb_mc_cfg_loader.sv - randomized self-checking bench for mc_cfg_loader
module tb_mc_cfg_loader;

  localparam int N  = 4;
  localparam int NB = 4 * N;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, cfg_bit, cfg_valid;
  logic          cfg_ready, busy, done, err;
  logic [N-1:0]  xor_inv_mux, o_mux, d_mux;
  logic [MW-1:0] err_mc;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0]  exp_x, exp_o, exp_d;
  logic          exp_err;
  logic [MW-1:0] exp_err_mc;

  always #5 clk = ~clk;

  mc_cfg_loader #(.NUM_MC(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_bit     (cfg_bit),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .xor_inv_mux (xor_inv_mux),
    .o_mux       (o_mux),
    .d_mux       (d_mux),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_mc      (err_mc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] good_stream();
    logic [NB-1:0] s;
    logic [2:0]    f;
    s = '0;
    for (int m = 0; m < N; m++) begin
      f = 3'($urandom);
      s[4*m +: 3] = f;
      s[4*m + 3]  = ~^f;
    end
    return s;
  endfunction

  function automatic int first_bad(input logic [NB-1:0] s);
    for (int m = 0; m < N; m++) begin
      if ((^s[4*m +: 4]) == 1'b0) return m;
    end
    return -1;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_xinv"}, 32'(xor_inv_mux), 32'(exp_x));
    chk({tag, "_omux"}, 32'(o_mux), 32'(exp_o));
    chk({tag, "_dmux"}, 32'(d_mux), 32'(exp_d));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_errmc"}, 32'(err_mc), 32'(exp_err_mc));
  endtask

  // Called at a negedge; runs one start + stream and checks the outcome.
  // abort_at: stream index presented together with abort (-1 = none).
  task automatic do_load(input string tag, input logic [NB-1:0] s, input bit stall,
                         input int abort_at, input bit noisy_start);
    int  bad_mc, n, idx, done_n, extra_done, exp_n, outcome;
    bit  v, ab, ended;
    bad_mc = first_bad(s);
    exp_n  = stall ? 2 * NB + 1 : NB + 1;
    // 0 = commit, 1 = parity error, 2 = abort
    if (abort_at >= 0 && (bad_mc < 0 || abort_at <= 4 * bad_mc + 3)) outcome = 2;
    else if (bad_mc >= 0) outcome = 1;
    else outcome = 0;

    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    exp_err = 1'b0;
    exp_err_mc = '0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_start"}, 32'(cfg_ready), 32'd1);

    n = 0; idx = 0; ended = 0; done_n = -1;
    while (!ended && n < 4 * NB + 20) begin
      v  = (idx < NB) && (!stall || (n % 2 == 1));
      ab = v && (idx == abort_at);
      cfg_valid = v;
      cfg_bit   = v ? s[idx] : 1'b0;
      abort     = ab;
      start     = (noisy_start && v) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
      cfg_valid = 1'b0; abort = 1'b0; start = 1'b0;
      if (ab) ended = 1;
      else if (v) begin
        if (idx % 4 == 3 && idx / 4 == bad_mc) ended = 1;
        idx++;
      end
      if (done) begin
        done_n = n;
        ended  = 1;
      end
    end
    chk({tag, "_ended"}, 32'(ended), 32'd1);

    if (outcome == 0) begin
      chk({tag, "_latency"}, 32'(done_n), 32'(exp_n));
      for (int m = 0; m < N; m++) begin
        exp_x[m] = s[4*m];
        exp_o[m] = s[4*m + 1];
        exp_d[m] = s[4*m + 2];
      end
    end else begin
      chk({tag, "_nodone"}, 32'(done_n), 32'hffff_ffff);
      if (outcome == 1) begin
        exp_err    = 1'b1;
        exp_err_mc = MW'(bad_mc);
      end
    end
    check_model(tag);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_rdy_end"}, 32'(cfg_ready), 32'd0);

    extra_done = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extra_done++;
    end
    chk({tag, "_no_extra_done"}, 32'(extra_done), 32'd0);
    check_model({tag, "_hold"});
  endtask

  // Streams good bits back to back and asserts rst on loop cycle r.
  task automatic reset_during(input string tag, input logic [NB-1:0] s, input int r);
    int idx;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    for (int n = 0; n <= r; n++) begin
      cfg_valid = (idx < NB);
      cfg_bit   = (idx < NB) ? s[idx] : 1'b0;
      rst       = (n == r);
      @(posedge clk);
      if (idx < NB) idx++;
      @(negedge clk);
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    exp_x = '0; exp_o = '0; exp_d = '0; exp_err = 1'b0; exp_err_mc = '0;
    check_model(tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  logic [NB-1:0] s_full, s_bad, s_rnd;
  int            bm;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_bit = 1'b0; cfg_valid = 1'b0;
    exp_x = '0; exp_o = '0; exp_d = '0; exp_err = 1'b0; exp_err_mc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model("reset");
    chk("reset_rdy", 32'(cfg_ready), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // mc0=1,0,1,1 mc1=0,1,1,1 mc2=0,0,0,1 mc3=1,1,1,0 (bit 0 sent first)
    s_full = 16'b0111_1000_1110_1101;
    do_load("full", s_full, 1'b0, -1, 1'b0);
    chk("full_xinv_lit", 32'(xor_inv_mux), 32'b1001);
    chk("full_omux_lit", 32'(o_mux), 32'b1010);
    chk("full_dmux_lit", 32'(d_mux), 32'b1011);

    s_bad = s_full;
    s_bad[11] = 1'b0;
    do_load("parity", s_bad, 1'b0, -1, 1'b0);
    do_load("recover", good_stream(), 1'b0, -1, 1'b0);

    do_load("parity2", s_bad, 1'b0, -1, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("err_start_abort_busy", 32'(busy), 32'd0);
    chk("err_start_abort_err", 32'(err), 32'd1);

    do_load("abort9", good_stream(), 1'b0, 9, 1'b0);
    do_load("abort_last", good_stream(), 1'b0, NB - 1, 1'b0);
    do_load("abort_badpar", s_bad, 1'b0, 11, 1'b0);

    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_start_abort_busy", 32'(busy), 32'd0);
    chk("idle_start_abort_rdy", 32'(cfg_ready), 32'd0);

    do_load("stall", s_full, 1'b1, -1, 1'b1);

    for (int it = 0; it < 24; it++) begin
      s_rnd = good_stream();
      if ($urandom_range(0, 3) == 0) begin
        bm = $urandom_range(0, N - 1);
        s_rnd[4*bm + 3] = ~s_rnd[4*bm + 3];
      end
      do_load($sformatf("rnd%0d", it), s_rnd, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, NB - 1) : -1,
              1'($urandom_range(0, 1)));
    end

    do_load("pre_rst1", s_full, 1'b0, -1, 1'b0);
    reset_during("rst_commit", good_stream(), NB);
    do_load("pre_rst2", s_full, 1'b0, -1, 1'b0);
    reset_during("rst_load", good_stream(), 6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_cfg_loader.md
Name: mc_cfg_loader

Overview:
- Serial configuration loader for a bank of NUM_MC macrocell XOR/output nests.
- Drives each macrocell's three select lines: xor_inv_mux, o_mux (which also serves as dfast_mux) and d_mux.
- Accepts a valid/ready bit stream with odd parity per macrocell, stages it in shadow registers, and commits all macrocells atomically.
- Sits between the fuse-stream source and the macrocell array; the active configuration never changes partway through a load.

Parameters:
- NUM_MC, 16, number of macrocells configured; must be >= 1.
- MCW, $clog2(NUM_MC) (min 1), width of macrocell index.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin load; sampled in IDLE or ERROR only
- abort  input  1  cancel load in progress
- cfg_bit  input  1  serial config bit
- cfg_valid  input  1  cfg_bit valid
- cfg_ready  output  1  loader accepts bit this cycle
- xor_inv_mux  output  NUM_MC  active per-macrocell invert select
- o_mux  output  NUM_MC  active per-macrocell y2/q select
- d_mux  output  NUM_MC  active per-macrocell FF D select
- busy  output  1  high in LOAD and COMMIT
- done  output  1  one-cycle pulse, new config active
- err  output  1  sticky parity error
- err_mc  output  MCW  index of macrocell that failed parity

Behaviour:
- Single clock domain: clk. Reset: rst, synchronous, active-high.
- Reset values: xor_inv_mux, o_mux, d_mux, shadow regs, err_mc = 0; cfg_ready, busy, done, err = 0; state = IDLE; counters = 0.
- Stream format: 4*NUM_MC bits, macrocell 0 first. Per macrocell, in order: b0 xor_inv_mux, b1 o_mux, b2 d_mux, b3 parity.
- Parity rule: b0^b1^b2^b3 must equal 1 (odd parity).
- Bit acceptance: a bit is accepted on an edge where cfg_valid && cfg_ready. cfg_ready is a registered function of state and is high only in LOAD.
- Counters: bit_idx (2 bits, 0..3) and mc_idx (0..NUM_MC-1).
  - Both clear on entry to LOAD.
  - bit_idx wraps 3 -> 0 and increments mc_idx on the wrap.
- States:
  - IDLE: start -> LOAD.
  - LOAD: accept bits into shadow[mc_idx].
    - On an accepted b3 with bad parity -> ERROR; err_mc <= mc_idx, err <= 1.
    - On an accepted b3 with good parity and mc_idx == NUM_MC-1 -> COMMIT.
    - abort -> IDLE; shadow discarded; active outputs unchanged.
    - start is ignored in LOAD.
  - COMMIT: one cycle. Active outputs <= shadow, done <= 1, next state IDLE.
    - done and the new outputs become visible on the same edge.
  - ERROR: cfg_ready = 0; active outputs unchanged; err held.
    - start clears err and err_mc and enters LOAD.
    - abort in ERROR -> IDLE with err still set.
- Latency: final bit accepted on edge k -> outputs updated and done = 1 on edge k+1.
  - Back-to-back valid bits give 4*NUM_MC+1 edges from the start edge to done.
- Simultaneous events:
  - abort with the final accepted bit: abort wins, no commit.
  - abort with a bad-parity b3: abort wins, err not set.
  - start and abort together in IDLE/ERROR: abort wins, stay or go IDLE.
- Gaps: cfg_valid low stalls the counters with no timeout.
- Reset mid-load or in COMMIT: all registers return to reset values, including active outputs.
- done is never high while err is high.

Decomposition:
- Package mc_cfg_pkg:
  - state enum {IDLE, LOAD, COMMIT, ERROR};
  - BITS_PER_MC = 4;
  - field offsets XINV = 0, OMUX = 1, DMUX = 2, PAR = 3.
- Sub-module mc_cfg_slot, one per macrocell:
  - 3-bit shadow plus 3-bit active register;
  - shadow write-enable per bit;
  - commit strobe;
  - parity accumulator output.
- Top level keeps the FSM, counters, handshake and error capture.

Test Plan (NUM_MC=4):
- Full load: stream the good patterns mc0 = 1,0,1,1; mc1 = 0,1,1,1; mc2 = 0,0,0,1; mc3 = 1,1,1,0, with cfg_valid held high.
  - Required: done pulses exactly 17 edges after start.
  - Required: xor_inv_mux = 4'b1001, o_mux = 4'b1010, d_mux = 4'b1011.
- Parity error: as the full load, but mc2 parity bit = 0.
  - Required: ERROR with err = 1 and err_mc = 2.
  - Required: cfg_ready low, outputs retain the prior values, no done.
  - Then start plus a good stream: err clears and the commit succeeds.
- Abort: abort asserted after 9 accepted bits.
  - Required: IDLE, busy = 0, outputs unchanged, no done.
  - Also drive abort on the same edge as bit 16: no commit.
- Stall: cfg_valid toggled every other cycle.
  - Required: commit after 33 edges with the same result as the full load.
  - Required: start pulses during LOAD are ignored.
- Reset: rst asserted in the COMMIT cycle and again mid-LOAD.
  - Required: next cycle all outputs 0, state IDLE, cfg_ready 0.
